// File: rtl/bw_io_impctl_pkg.sv
// bw_io_impctl_pkg: update-scheduler state encodings and round-robin index helper
package bw_io_impctl_pkg;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GRANT  = 3'd1,
    S_TRIG   = 3'd2,
    S_WAIT   = 3'd3,
    S_SETTLE = 3'd4,
    S_DONE   = 3'd5
  } state_t;
  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/bw_io_impctl_rrarb.sv
// bw_io_impctl_rrarb: combinational round-robin picker, first request at/after ptr
module bw_io_impctl_rrarb
  import bw_io_impctl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_pick,
  output logic [IW-1:0]   o_pick_idx
);
  logic [IW-1:0] w_i;
  always_comb begin
    o_pick_idx = '0;
    w_i = '0;
    // scan farthest offset first so the nearest request at/after ptr wins
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_i = IW'(wrap_add(int'(i_ptr), k, NREQ));
      if (i_req[w_i]) o_pick_idx = w_i;
    end
    o_pick = |i_req ? NREQ'(1) << o_pick_idx : '0;
  end
endmodule

// File: rtl/bw_io_impctl_updsched.sv
// bw_io_impctl_updsched: round-robin scheduler of impedance-update requests onto the
// shared update-clock generator, with edge counting, settle delay and timeout abort
module bw_io_impctl_updsched
  import bw_io_impctl_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int UPD_CNT    = 2,
  parameter int SETTLE_CYC = 8,
  parameter int TMOW       = 10,
  parameter int TMO_CYC    = 1023
) (
  input  logic            l2clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            synced_upd_imped,
  output logic            sclk_en,
  input  logic            updclk,
  input  logic            bypass,
  output logic            busy,
  output logic            tmo_sticky
);
  localparam int IW = $clog2(NREQ);
  localparam int EW = $clog2(UPD_CNT + 1);
  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_gidx, w_pick_idx;
  logic [NREQ-1:0] r_gnt, w_pick;
  logic [EW-1:0]   r_edge_cnt;
  logic [TMOW-1:0] r_tmo_cnt;
  logic [7:0]      r_set_cnt;
  logic            r_updclk_q, r_err, r_tmo_sticky;
  logic            w_edge, w_term, w_tmo;

  bw_io_impctl_rrarb #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req      (req),
    .i_ptr      (r_ptr),
    .o_pick     (w_pick),
    .o_pick_idx (w_pick_idx)
  );

  assign w_edge = updclk & ~r_updclk_q;
  // a terminating edge takes priority over a simultaneous timeout
  assign w_term = (r_state == S_WAIT) && w_edge && (r_edge_cnt == EW'(UPD_CNT - 1));
  assign w_tmo  = (r_state == S_WAIT) && !w_term && (r_tmo_cnt == TMOW'(TMO_CYC));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = (|req && !bypass) ? S_GRANT : S_IDLE;
      S_GRANT:  w_next = S_TRIG;
      S_TRIG:   w_next = S_WAIT;
      S_WAIT:   w_next = w_term ? S_SETTLE : w_tmo ? S_DONE : S_WAIT;
      S_SETTLE: w_next = (r_set_cnt == 8'(SETTLE_CYC - 1)) ? S_DONE : S_SETTLE;
      default:  w_next = S_IDLE;
    endcase
    busy             = r_state != S_IDLE;
    gnt              = (busy && r_state != S_DONE) ? r_gnt : '0;
    done             = (r_state == S_DONE) ? NREQ'(1) << r_gidx : '0;
    err              = (r_state == S_DONE) && r_err;
    synced_upd_imped = r_state == S_TRIG;
    sclk_en          = r_state == S_WAIT;
    tmo_sticky       = r_tmo_sticky;
  end

  always_ff @(posedge l2clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_gidx       <= '0;
      r_gnt        <= '0;
      r_edge_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_set_cnt    <= '0;
      r_updclk_q   <= 1'b0;
      r_err        <= 1'b0;
      r_tmo_sticky <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_updclk_q <= updclk;
      if (r_state == S_IDLE && w_next == S_GRANT) begin
        r_gnt  <= w_pick;
        r_gidx <= w_pick_idx;
      end
      if (r_state == S_TRIG) begin
        r_edge_cnt <= '0;
        r_tmo_cnt  <= '0;
        r_err      <= 1'b0;
      end
      if (r_state == S_WAIT) begin
        if (w_edge) r_edge_cnt <= r_edge_cnt + EW'(1);
        if (!(&r_tmo_cnt)) r_tmo_cnt <= r_tmo_cnt + TMOW'(1);
        if (w_term) r_set_cnt <= '0;
        if (w_tmo) begin
          r_err        <= 1'b1;
          r_tmo_sticky <= 1'b1;
        end
      end
      if (r_state == S_SETTLE) r_set_cnt <= r_set_cnt + 8'd1;
      if (r_state == S_DONE) r_ptr <= IW'(wrap_add(int'(r_gidx), 1, NREQ));
    end
  end
endmodule
